// File: rtl/ifetch_pc_unit.sv
// ---------------------------------------------------------------------------
// ifetch_pc_unit
//
// Instruction-fetch stage. Owns the program counter, drives the synchronous
// program memory and holds the fetched instruction register (IR). It supplies
// the opcode decoded by the downstream stall block. It also obeys two inputs
// from that block:
//   stall    : a multi-cycle op is executing. Issue bubbles and hold PC/IR.
//   stall_pm : the program memory is busy. Freeze the whole stage.
//
// Ports
//   clk            in   1        system clock, rising edge
//   reset          in   1        asynchronous, active-high reset
//   stall          in   1        hold PC/IR, ir_valid forced low
//   stall_pm       in   1        freeze the entire stage
//   branch_taken   in   1        redirect request from execute
//   branch_target  in   PC_W     redirect address
//   pm_addr        out  PC_W     program-memory read address (= pc_q)
//   pm_en          out  1        program-memory read enable
//   pm_rdata       in   INSTR_W  read data, valid one cycle after pm_en=1
//   ir             out  INSTR_W  instruction register
//   ir_pc          out  PC_W     address of the instruction held in ir
//   ir_valid       out  1        ir holds a real instruction for decode
//   op             out  6        ir[INSTR_W-1 -: 6], to the stall block
//   fetch_count    out  16       instructions accepted into IR (wraps)
//   fetch_state    out  1        debug view of the FILL/RUN state register
//
// Handshake: the memory behaves as valid/ready with a fixed one-cycle
// latency. A read issued with pm_en=1 in cycle N returns on pm_rdata during
// cycle N+1. While pm_en=0, the memory keeps presenting the last read data.
// A read is "wanted" only when the FILL/RUN state is RUN in the cycle that
// consumes it. A redirect or reset marks any in-flight data as unwanted.
// ---------------------------------------------------------------------------
module ifetch_pc_unit #(
  parameter int                  PC_W      = 16,
  parameter int                  INSTR_W   = 32,
  parameter logic [PC_W-1:0]     RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               stall_pm,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    pm_addr,
  output logic               pm_en,
  input  logic [INSTR_W-1:0] pm_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  output logic [5:0]         op,
  output logic [15:0]        fetch_count,
  output logic               fetch_state
);

  // FILL: the data on pm_rdata next cycle is not a wanted fetch.
  // RUN : it is the instruction at addr_q.
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] addr_q;
  logic [0:0]      state_q;

  // Cycle classification, in priority order:
  // stall_pm > branch_taken > stall > normal.
  logic freeze;
  logic redirect;
  logic hold;
  logic advance;

  always_comb begin
    freeze   = 1'b0;
    redirect = 1'b0;
    hold     = 1'b0;
    advance  = 1'b0;
    if (stall_pm) begin
      freeze = 1'b1;
    end else if (branch_taken) begin
      redirect = 1'b1;
    end else if (stall) begin
      hold = 1'b1;
    end else begin
      advance = 1'b1;
    end
  end

  // A read is issued only on normal cycles. It is held off while reset is
  // asserted, so the first read goes out right after deassertion.
  assign pm_en       = advance & ~reset;
  assign pm_addr     = pc_q;
  assign op          = ir[INSTR_W-1 -: 6];
  assign fetch_state = state_q[0];

  // Program counter and issued-address register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      addr_q <= '0;
    end else if (redirect) begin
      pc_q <= branch_target;
    end else if (advance) begin
      addr_q <= pc_q;
      pc_q   <= pc_q + PC_W'(1);
    end
  end

  // FILL/RUN state. A redirect discards the in-flight read. Any normal
  // cycle issues a read, so the next cycle's data is wanted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
    end else if (redirect) begin
      state_q <= ST_FILL;
    end else if (advance) begin
      state_q <= ST_RUN;
    end
  end

  // Instruction register and its companions. During a stall the opcode
  // stays visible on op, so the stall block can keep counting, but
  // ir_valid drops so decode does not issue it twice. The memory keeps its
  // last read data while pm_en=0. The first normal cycle after the stall
  // therefore loads the pending instruction, and none is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir          <= NOP_INSTR;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
      fetch_count <= '0;
    end else if (redirect) begin
      ir       <= NOP_INSTR;
      ir_valid <= 1'b0;
    end else if (hold) begin
      ir_valid <= 1'b0;
    end else if (advance) begin
      if (state_q == ST_RUN) begin
        ir          <= pm_rdata;
        ir_pc       <= addr_q;
        ir_valid    <= 1'b1;
        fetch_count <= fetch_count + 16'd1;
      end else begin
        ir       <= NOP_INSTR;
        ir_valid <= 1'b0;
      end
    end
  end

endmodule
